// File: rtl/alu_md_unit.sv
// alu_md_unit: RV-style base ALU plus iterative multiply/divide (M ops), optional early-out via ALU_MD_EARLY_OUT_EN.
// Latency: base ops 1 cycle; M ops XLEN+1 cycles (1 cycle for trivial M ops when ALU_MD_EARLY_OUT_EN is defined).
// Backpressure: start is only accepted while busy=0; starts while busy (CALC/FIN) are dropped, flush aborts silently.
module alu_md_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic [XLEN-1:0] Result,
  output logic            Zero,
  output logic            busy,
  output logic            done
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                zero_q, zero_d;

  // rs1 is treated as signed for MULH, MULHSU, DIV, REM
  function automatic logic a_signed(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
  endfunction

  // rs2 is treated as signed for MULH, DIV, REM
  function automatic logic b_signed(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
  endfunction

  // Magnitude of a value; the most-negative value maps to 2^(XLEN-1) as unsigned
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

  // Single-cycle base ALU operations
  function automatic logic [XLEN-1:0] alu_base(input logic [3:0] code,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [SW-1:0]   sh;
    logic [XLEN-1:0] r;
    sh = b[SW-1:0];
    case (code)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a << sh;
      4'b0011: r = $signed(a) >>> sh;
      4'b0100: r = a ^ b;
      4'b0101: r = a >> sh;
      4'b0110: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b0111: r = {{(XLEN-1){1'b0}}, (a < b)};
      4'b1000: r = a | b;
      4'b1001: r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // One iteration: shift-add multiply (acc = {partial, multiplier}) or
  // restoring divide (acc = {remainder, dividend/quotient})
  function automatic logic [2*XLEN-1:0] md_step(input logic [2:0] f3,
                                                input logic [2*XLEN-1:0] acc,
                                                input logic [XLEN-1:0] opnd);
    logic [XLEN:0]       sum;
    logic [XLEN:0]       tmp;
    logic [2*XLEN-1:0]   nxt;
    if (!f3[2]) begin
      sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      nxt = {sum, acc[XLEN-1:1]};
    end else begin
      tmp = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      if (tmp >= {1'b0, opnd}) begin
        nxt = {tmp[XLEN-1:0] - opnd, acc[XLEN-2:0], 1'b1};
      end else begin
        nxt = {tmp[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
    end
    return nxt;
  endfunction

  // Sign fix-up, half selection and divide corner cases applied on entry to FIN
  function automatic logic [XLEN-1:0] md_final(input logic [2:0] f3,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b,
                                               input logic [2*XLEN-1:0] acc);
    logic              sa, sb;
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   q, rm, r;
    sa = a_signed(f3) & a[XLEN-1];
    sb = b_signed(f3) & b[XLEN-1];
    if (!f3[2]) begin
      p = (sa ^ sb) ? -acc : acc;
      r = (f3[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    end else begin
      q  = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rm = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      if (b == '0) begin
        q  = '1;
        rm = a;
      end else if (b_signed(f3) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)) begin
        q  = a;
        rm = '0;
      end
      r = f3[1] ? rm : q;
    end
    return r;
  endfunction

`ifdef ALU_MD_EARLY_OUT_EN
  // M ops whose result is known without iterating
  function automatic logic early_out(input logic [2:0] f3,
                                     input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
    logic ovf;
    ovf = b_signed(f3) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    if (!f3[2]) return (a == '0) || (b == '0);
    return (b == '0) || ovf;
  endfunction
`endif

  // Next-state, operand capture, iteration and result update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    a_d      = a_q;
    b_d      = b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          f3_d  = op[2:0];
          a_d   = A;
          b_d   = B;
          cnt_d = '0;
          if (!op[4]) begin
            result_d = alu_base(op[3:0], A, B);
            state_d  = FIN;
          end else begin
            if (!op[2]) begin
              acc_d  = {{XLEN{1'b0}}, mag(B, b_signed(op[2:0]))};
              opnd_d = mag(A, a_signed(op[2:0]));
            end else begin
              acc_d  = {{XLEN{1'b0}}, mag(A, a_signed(op[2:0]))};
              opnd_d = mag(B, b_signed(op[2:0]));
            end
            state_d = CALC;
`ifdef ALU_MD_EARLY_OUT_EN
            if (early_out(op[2:0], A, B)) begin
              result_d = md_final(op[2:0], A, B, '0);
              state_d  = FIN;
            end
`endif
          end
        end
      end
      CALC: begin
        acc_d = md_step(f3_q, acc_q, opnd_q);
        cnt_d = cnt_q + CW'(1);
        if (cnt_d == CNT_LAST) begin
          result_d = md_final(f3_q, a_q, b_q, acc_d);
          state_d  = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
    zero_d = (result_d == '0);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign Result = result_q;
  assign Zero   = zero_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == FIN);

endmodule

// File: doc/alu_md_unit.md
ALU_MD_UNIT -- requirements
Module: alu_md_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal values 8..64, even).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port start  input  1  request; accepted only when busy=0.
REQ-005 SHALL have port flush  input  1  abort in-flight operation, no done pulse.
REQ-006 SHALL have port op  input  5  op[4]=0: base ALU code in op[3:0]; op[4]=1: M-op, funct3 in op[2:0].
REQ-007 SHALL have port A  input  XLEN  operand A (rs1).
REQ-008 SHALL have port B  input  XLEN  operand B (rs2/imm).
REQ-009 SHALL have port Result  output  XLEN  registered result.
REQ-010 SHALL have port Zero  output  1  registered (Result == 0).
REQ-011 SHALL have port busy  output  1  operation in flight; start ignored.
REQ-012 SHALL have port done  output  1  one-cycle pulse, Result/Zero valid.

Function
REQ-013 Base codes SHALL be: 0000 add, 0001 sub, 0010 sll, 0011 sra, 0100 xor, 0101 srl, 0110 slt, 0111 sltu, 1000 or, 1001 and, 1010-1111 result 0; shift amount B[log2(XLEN)-1:0].
REQ-014 M codes (op[2:0]) SHALL be: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU, per RV32M semantics at width XLEN.
REQ-015 Operands and op SHALL be captured in internal registers on the accepting edge; later input changes have no effect.
REQ-016 FSM SHALL have states IDLE, CALC, FIN; IDLE->FIN on base-op start, IDLE->CALC on M-op start, CALC->FIN when iteration counter reaches XLEN, FIN->IDLE unconditionally.
REQ-017 Base op latency SHALL be 1: start at edge N -> done=1 and Result valid during cycle after edge N+1.
REQ-018 M op latency SHALL be XLEN+1 cycles from accepting edge to done (33 for XLEN=32), fixed unless REQ-029 applies.
REQ-019 Multiply SHALL be iterative shift-add over 2*XLEN-bit product on operand magnitudes, sign fixed at FIN; MUL returns low half, MULH/MULHSU/MULHU high half.
REQ-020 Divide SHALL be iterative restoring, one quotient bit per cycle, on magnitudes; quotient sign = sign(A) xor sign(B), remainder sign = sign(A) for signed ops.
REQ-021 Divide by zero SHALL give quotient all-ones and remainder = A (DIV, DIVU, REM, REMU).
REQ-022 Signed overflow (A = most-negative, B = -1) SHALL give DIV quotient = A, REM = 0.
REQ-023 busy SHALL be 1 in CALC and FIN, 0 in IDLE; start while busy=1 SHALL be dropped silently.
REQ-024 done SHALL be 1 exactly in FIN; Result and Zero SHALL hold their value until the next done.
REQ-025 flush SHALL take priority over start and iteration: next state IDLE, no done, Result/Zero unchanged; start in the same cycle as flush is dropped.
REQ-026 Back-to-back: start asserted while in FIN is dropped; earliest next accept is the cycle after done.

Reset
REQ-027 rst SHALL force state IDLE, busy=0, done=0, Result=0, Zero=1, counter and internal registers 0, on the next rising edge, overriding flush and start.
REQ-028 rst asserted mid-CALC SHALL abort the operation with no done pulse; first start after rst deassertion SHALL complete normally.

Configuration
REQ-029 Macro ALU_MD_EARLY_OUT_EN: when defined, M ops with B=0, signed divide overflow, or A=0/B=0 multiply SHALL go IDLE->FIN with latency 1 and REQ-021/022 results (product 0); when undefined, all M ops take XLEN+1 cycles with identical results.

Verification
REQ-030 XLEN=32, op=0_0001, A=5, B=5, start -> done one cycle later, Result=0, Zero=1.
REQ-031 op=1_0001 MULH, A=0x80000000, B=0x80000000 -> after 33 cycles done, Result=0x40000000.
REQ-032 op=1_0100 DIV, A=0x80000000, B=0xFFFFFFFF -> Result=0x80000000; REM same operands -> Result=0; latency 33 without macro, 1 with.
REQ-033 op=1_0101 DIVU, A=7, B=0 -> Result=0xFFFFFFFF; REMU -> Result=7.
REQ-034 Start DIVU 100/7, flush at cycle 10 -> no done, busy=0 next cycle, Result holds prior value; new REMU 100/7 -> Result=2.
REQ-035 Start MUL, assert rst at cycle 5, second start during busy -> Result=0, Zero=1, no done; second start dropped.
